i2c_config_seq: RTL

I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

---
 rtl/i2c_cfg_pkg.sv | 20 ++
 rtl/i2c_config_seq_if.sv | 30 +++
 rtl/i2c_cfg_lut.sv | 22 ++
 rtl/i2c_config_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer: state encoding and
// default timing/retry parameters.
package i2c_cfg_pkg;

    localparam int unsigned ClkDivDefault   = 500;
    localparam int unsigned MaxRetryDefault = 3;
    localparam logic [7:0]  TimeoutDefault  = 8'd80;

    typedef enum logic [2:0] {
        StPwrup,
        StLoad,
        StIssue,
        StWaitEnd,
        StCheck,
        StGap,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/i2c_config_seq_if.sv
// Bundle of table and transfer-controller signals between the sequencer, its
// configuration ROM and the I2C byte engine.
interface i2c_config_seq_if;

    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic        i2c_clk;
    logic        i2c_en;
    logic [23:0] wdata;
    logic        wr;
    logic        go;
    logic        xfer_end;
    logic        ack;

    modport master (
        output lut_index, i2c_clk, i2c_en, wdata, wr, go,
        input  lut_data, xfer_end, ack
    );

    modport slave (
        input  lut_index, i2c_clk, i2c_en, wdata, wr, go,
        output lut_data, xfer_end, ack
    );

    modport lut (
        input  lut_index,
        output lut_data
    );

endinterface

// File: rtl/i2c_cfg_lut.sv
// Configuration ROM: {slave addr, sub addr, data} per 8-bit table index.
// Purely combinational; unused indices read as zero.
module i2c_cfg_lut (
    i2c_config_seq_if.lut lut_io
);

    always_comb begin
        lut_io.lut_data = 24'h00_0000;
        case (lut_io.lut_index)
            8'd0:    lut_io.lut_data = 24'h34_1E_00;
            8'd1:    lut_io.lut_data = 24'h34_08_12;
            8'd2:    lut_io.lut_data = 24'h34_0C_00;
            8'd3:    lut_io.lut_data = 24'h34_0A_06;
            8'd4:    lut_io.lut_data = 24'h34_0E_01;
            8'd5:    lut_io.lut_data = 24'h34_10_00;
            8'd6:    lut_io.lut_data = 24'h34_12_01;
            8'd7:    lut_io.lut_data = 24'h34_00_17;
            default: lut_io.lut_data = 24'h00_0000;
        endcase
    end

endmodule

// File: rtl/i2c_config_seq.sv
// Walks a configuration table after power-up, issuing one I2C write per entry
// with bounded retries and a per-transfer tick timeout.
module i2c_config_seq
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV   = ClkDivDefault,
    parameter logic [7:0]  LUT_SIZE  = 8'd32,
    parameter int unsigned MAX_RETRY = MaxRetryDefault,
    parameter logic [19:0] PWRUP_DLY = 20'd500000,
    parameter logic [7:0]  TIMEOUT   = TimeoutDefault
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        START,
    output logic [7:0]  LUT_INDEX,
    input  logic [23:0] LUT_DATA,
    output logic        I2C_CLK,
    output logic        I2C_EN,
    output logic [23:0] I2C_WDATA,
    output logic        WR,
    output logic        GO,
    input  logic        END,
    input  logic        ACK,
    output logic        CFG_DONE,
    output logic        CFG_ERR,
    output logic [7:0]  ERR_INDEX
);

    localparam int unsigned DivW   = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
    localparam logic [7:0]      RetryMax = 8'(MAX_RETRY);

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [19:0]     dly_q, dly_d;
    logic [7:0]      tick_q, tick_d;
    logic [7:0]      retry_q, retry_d;
    logic [7:0]      idx_q, idx_d;
    logic [23:0]     wdata_q, wdata_d;
    logic            go_q, go_d;
    logic            fail_q, fail_d;
    logic [7:0]      err_idx_q, err_idx_d;

    logic tick_en;
    logic pwrup_done;
    logic timed_out;

    // Free-running divider, independent of the sequencer state.
    assign tick_en = (div_q == DivMax);
    assign div_d   = tick_en ? '0 : div_q + DivW'(1);

    assign pwrup_done = ({1'b0, dly_q} + 21'd1) >= {1'b0, PWRUP_DLY};
    assign timed_out  = ({1'b0, tick_q} + 9'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        tick_d    = tick_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        go_d      = go_q;
        fail_d    = fail_q;
        err_idx_d = err_idx_q;

        unique case (state_q)
            StPwrup: begin
                dly_d = dly_q + 20'd1;
                if (pwrup_done) begin
                    dly_d   = '0;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = (LUT_SIZE == 8'd0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                wdata_d = LUT_DATA;
                state_d = StIssue;
            end
            StIssue: begin
                // Hold off while the engine still reports END from a prior transfer.
                if (!END) begin
                    go_d    = 1'b1;
                    tick_d  = '0;
                    fail_d  = 1'b0;
                    state_d = StWaitEnd;
                end
            end
            StWaitEnd: begin
                if (tick_en) begin
                    tick_d = tick_q + 8'd1;
                    if (END) begin
                        fail_d  = ACK;
                        state_d = StCheck;
                    end else if (timed_out) begin
                        fail_d  = 1'b1;
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                go_d   = 1'b0;
                tick_d = '0;
                if (!fail_q) begin
                    idx_d   = idx_q + 8'd1;
                    retry_d = '0;
                    state_d = StGap;
                end else if (retry_q < RetryMax) begin
                    retry_d = retry_q + 8'd1;
                    state_d = StGap;
                end else begin
                    err_idx_d = idx_q;
                    state_d   = StError;
                end
            end
            StGap: begin
                // tick_q == 0: waiting for END low; then two more ticks of idle bus.
                if (tick_en) begin
                    if (tick_q == 8'd0) begin
                        if (!END) tick_d = 8'd1;
                    end else if (tick_q == 8'd2) begin
                        tick_d  = '0;
                        state_d = (idx_q == LUT_SIZE) ? StDone : StLoad;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
            end
            StDone, StError: begin
                go_d = 1'b0;
                if (START) begin
                    err_idx_d = '0;
                    idx_d     = '0;
                    retry_d   = '0;
                    state_d   = StLoad;
                end
            end
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= StPwrup;
            div_q     <= '0;
            dly_q     <= '0;
            tick_q    <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            go_q      <= 1'b0;
            fail_q    <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            dly_q     <= dly_d;
            tick_q    <= tick_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            go_q      <= go_d;
            fail_q    <= fail_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign I2C_EN    = tick_en;
    assign I2C_CLK   = (div_q >= DivHalf);
    assign LUT_INDEX = idx_q;
    assign I2C_WDATA = wdata_q;
    assign WR        = 1'b1;
    assign GO        = go_q;
    assign CFG_DONE  = (state_q == StDone);
    assign CFG_ERR   = (state_q == StError);
    assign ERR_INDEX = err_idx_q;

endmodule
